// File: rtl/qpu_icb_pkg.sv
// ITCM ICB arbiter shared types and widths.
// Source IDs tag each outstanding command with its owner.
package qpu_icb_pkg;

  localparam int QPU_ITCM_ADDR_WIDTH = 16;
  localparam int QPU_ITCM_DATA_WIDTH = 64;
  localparam int QPU_ITCM_OUTS_DEPTH = 2;

  typedef enum logic {
    SRC_IFU = 1'b0,
    SRC_LDR = 1'b1
  } icb_src_e;

  function automatic int qpu_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int qpu_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/qpu_icb_id_fifo.sv
// Source-ID FIFO for outstanding ITCM commands.
// Entries pop in order as ITCM responses complete.
module qpu_icb_id_fifo
  import qpu_icb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = qpu_ptr_w(DEPTH),
  localparam int CW = qpu_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  icb_src_e      din,
  input  logic          pop,
  output icb_src_e      dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  icb_src_e      mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers wrap mod DEPTH, count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/qpu_itcm_icb_arb.sv
// Two-port ICB arbiter (IFU fetch, loader) in front of the ITCM.
// Round-robin grant, loader lock, in-order response routing.
module qpu_itcm_icb_arb
  import qpu_icb_pkg::*;
#(
  parameter int AW = QPU_ITCM_ADDR_WIDTH,
  parameter int DW = QPU_ITCM_DATA_WIDTH,
  parameter int OUTS_DEPTH = QPU_ITCM_OUTS_DEPTH,
  localparam int MW = DW / 8,
  localparam int CW = qpu_cnt_w(OUTS_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          ldr_cmd_valid,
  output logic          ldr_cmd_ready,
  input  logic [AW-1:0] ldr_cmd_addr,
  input  logic          ldr_cmd_read,
  input  logic [DW-1:0] ldr_cmd_wdata,
  input  logic [MW-1:0] ldr_cmd_wmask,
  output logic          ldr_rsp_valid,
  input  logic          ldr_rsp_ready,
  output logic [DW-1:0] ldr_rsp_rdata,
  input  logic          loader_lock,
  output logic          itcm_cmd_valid,
  input  logic          itcm_cmd_ready,
  output logic [AW-1:0] itcm_cmd_addr,
  output logic          itcm_cmd_read,
  output logic [DW-1:0] itcm_cmd_wdata,
  output logic [MW-1:0] itcm_cmd_wmask,
  input  logic          itcm_rsp_valid,
  output logic          itcm_rsp_ready,
  input  logic [DW-1:0] itcm_rsp_rdata,
  output logic          lock_granted,
  output logic          arb_idle,
  output logic          arb_err
);

  icb_src_e      last_gnt;
  icb_src_e      hold_src;
  icb_src_e      sel;
  icb_src_e      head;
  logic          hold_vld;
  logic          req;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic          cmd_fire;
  logic          rsp_fire;
  logic          push_ifu;
  logic          pop_ifu;
  logic [CW-1:0] ifu_outs;

  // owner of the cmd channel: held grant, then lock, then round-robin
  always_comb begin
    sel = SRC_LDR;
    if (hold_vld) begin
      sel = hold_src;
    end else if (loader_lock) begin
      sel = SRC_LDR;
    end else if (ifu_cmd_valid && ldr_cmd_valid) begin
      sel = (last_gnt == SRC_IFU) ? SRC_LDR : SRC_IFU;
    end else if (ifu_cmd_valid) begin
      sel = SRC_IFU;
    end
  end

  assign req = (sel == SRC_IFU) ? ifu_cmd_valid : ldr_cmd_valid;

  assign itcm_cmd_valid = !rst && req && !fifo_full;
  assign cmd_fire       = itcm_cmd_valid && itcm_cmd_ready;
  assign ifu_cmd_ready  = cmd_fire && (sel == SRC_IFU);
  assign ldr_cmd_ready  = cmd_fire && (sel == SRC_LDR);

  assign itcm_cmd_addr  = (sel == SRC_IFU) ? ifu_cmd_addr : ldr_cmd_addr;
  assign itcm_cmd_read  = (sel == SRC_IFU) ? 1'b1 : ldr_cmd_read;
  assign itcm_cmd_wdata = (sel == SRC_IFU) ? '0 : ldr_cmd_wdata;
  assign itcm_cmd_wmask = (sel == SRC_IFU) ? '0 : ldr_cmd_wmask;

  assign ifu_rsp_valid = !rst && itcm_rsp_valid && !fifo_empty &&
                         (head == SRC_IFU);
  assign ldr_rsp_valid = !rst && itcm_rsp_valid && !fifo_empty &&
                         (head == SRC_LDR);
  assign ifu_rsp_rdata = itcm_rsp_rdata;
  assign ldr_rsp_rdata = itcm_rsp_rdata;

  // an empty FIFO swallows stray responses
  assign itcm_rsp_ready = !rst && (fifo_empty ||
                          ((head == SRC_IFU) ? ifu_rsp_ready : ldr_rsp_ready));
  assign rsp_fire = itcm_rsp_valid && itcm_rsp_ready && !fifo_empty;

  assign push_ifu = cmd_fire && (sel == SRC_IFU);
  assign pop_ifu  = rsp_fire && (head == SRC_IFU);

  assign lock_granted = !rst && loader_lock && (ifu_outs == '0);
  assign arb_idle     = rst || ((fifo_cnt == '0) &&
                        !ifu_cmd_valid && !ldr_cmd_valid);

  qpu_icb_id_fifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_fire),
    .din   (sel),
    .pop   (rsp_fire),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  // freeze the grant while a cmd waits on itcm_cmd_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_src <= SRC_IFU;
    end else if (cmd_fire) begin
      hold_vld <= 1'b0;
    end else if (itcm_cmd_valid) begin
      hold_vld <= 1'b1;
      hold_src <= sel;
    end
  end

  // round-robin history; reset so the IFU wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= SRC_LDR;
    end else if (cmd_fire) begin
      last_gnt <= sel;
    end
  end

  // IFU commands still in flight gate the loader lock
  always_ff @(posedge clk) begin
    if (rst) begin
      ifu_outs <= '0;
    end else begin
      case ({push_ifu, pop_ifu})
        2'b10:   ifu_outs <= ifu_outs + CW'(1);
        2'b01:   ifu_outs <= ifu_outs - CW'(1);
        default: ifu_outs <= ifu_outs;
      endcase
    end
  end

  // sticky flag for a response with nothing outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_err <= 1'b0;
    end else if (itcm_rsp_valid && fifo_empty) begin
      arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qpu_itcm_icb_arb.sv
// Self-checking bench for qpu_itcm_icb_arb.
// Directed scenarios plus random traffic against a queue model.
module tb_qpu_itcm_icb_arb;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_cmd_valid;
  logic          ifu_cmd_ready;
  logic [AW-1:0] ifu_cmd_addr;
  logic          ifu_rsp_valid;
  logic          ifu_rsp_ready;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          ldr_cmd_valid;
  logic          ldr_cmd_ready;
  logic [AW-1:0] ldr_cmd_addr;
  logic          ldr_cmd_read;
  logic [DW-1:0] ldr_cmd_wdata;
  logic [MW-1:0] ldr_cmd_wmask;
  logic          ldr_rsp_valid;
  logic          ldr_rsp_ready;
  logic [DW-1:0] ldr_rsp_rdata;
  logic          loader_lock;
  logic          itcm_cmd_valid;
  logic          itcm_cmd_ready;
  logic [AW-1:0] itcm_cmd_addr;
  logic          itcm_cmd_read;
  logic [DW-1:0] itcm_cmd_wdata;
  logic [MW-1:0] itcm_cmd_wmask;
  logic          itcm_rsp_valid;
  logic          itcm_rsp_ready;
  logic [DW-1:0] itcm_rsp_rdata;
  logic          lock_granted;
  logic          arb_idle;
  logic          arb_err;

  int errors = 0;
  int checks = 0;

  // model: queue of owners in flight, last winner, pending owner
  bit mq[$];
  bit m_last;
  bit m_pend;
  bit m_pown;
  bit m_err;

  bit e_cv, e_ir, e_lr, e_own, e_rr;
  bit e_irv, e_lrv, e_lg, e_idle;

  qpu_itcm_icb_arb dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_cmd_valid  (ifu_cmd_valid),
    .ifu_cmd_ready  (ifu_cmd_ready),
    .ifu_cmd_addr   (ifu_cmd_addr),
    .ifu_rsp_valid  (ifu_rsp_valid),
    .ifu_rsp_ready  (ifu_rsp_ready),
    .ifu_rsp_rdata  (ifu_rsp_rdata),
    .ldr_cmd_valid  (ldr_cmd_valid),
    .ldr_cmd_ready  (ldr_cmd_ready),
    .ldr_cmd_addr   (ldr_cmd_addr),
    .ldr_cmd_read   (ldr_cmd_read),
    .ldr_cmd_wdata  (ldr_cmd_wdata),
    .ldr_cmd_wmask  (ldr_cmd_wmask),
    .ldr_rsp_valid  (ldr_rsp_valid),
    .ldr_rsp_ready  (ldr_rsp_ready),
    .ldr_rsp_rdata  (ldr_rsp_rdata),
    .loader_lock    (loader_lock),
    .itcm_cmd_valid (itcm_cmd_valid),
    .itcm_cmd_ready (itcm_cmd_ready),
    .itcm_cmd_addr  (itcm_cmd_addr),
    .itcm_cmd_read  (itcm_cmd_read),
    .itcm_cmd_wdata (itcm_cmd_wdata),
    .itcm_cmd_wmask (itcm_cmd_wmask),
    .itcm_rsp_valid (itcm_rsp_valid),
    .itcm_rsp_ready (itcm_rsp_ready),
    .itcm_rsp_rdata (itcm_rsp_rdata),
    .lock_granted   (lock_granted),
    .arb_idle       (arb_idle),
    .arb_err        (arb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return {~a, a, a ^ 16'hA5A5, 16'h3C3C};
  endfunction

  function automatic void model_eval();
    bit full, want;
    int n_ifu;
    full = (mq.size() == DEPTH);
    if (m_pend) e_own = m_pown;
    else if (loader_lock) e_own = 1'b1;
    else if (ifu_cmd_valid && ldr_cmd_valid) e_own = !m_last;
    else e_own = !ifu_cmd_valid;
    want = e_own ? ldr_cmd_valid : ifu_cmd_valid;
    e_cv = want && !full;
    e_ir = e_cv && !e_own && itcm_cmd_ready;
    e_lr = e_cv && e_own && itcm_cmd_ready;
    if (mq.size() == 0) begin
      e_rr = 1'b1;
      e_irv = 1'b0;
      e_lrv = 1'b0;
    end else begin
      e_irv = itcm_rsp_valid && !mq[0];
      e_lrv = itcm_rsp_valid && mq[0];
      e_rr = mq[0] ? ldr_rsp_ready : ifu_rsp_ready;
    end
    n_ifu = 0;
    foreach (mq[i]) if (!mq[i]) n_ifu++;
    e_lg = loader_lock && (n_ifu == 0);
    e_idle = (mq.size() == 0) && !ifu_cmd_valid && !ldr_cmd_valid;
  endfunction

  function automatic void model_commit();
    if (rst) begin
      mq.delete();
      m_last = 1'b1;
      m_pend = 1'b0;
      m_pown = 1'b0;
      m_err = 1'b0;
      return;
    end
    if (itcm_rsp_valid) begin
      if (mq.size() == 0) m_err = 1'b1;
      else if (e_rr) void'(mq.pop_front());
    end
    if (e_cv && itcm_cmd_ready) begin
      mq.push_back(e_own);
      m_last = e_own;
      m_pend = 1'b0;
    end else if (e_cv) begin
      m_pend = 1'b1;
      m_pown = e_own;
    end
  endfunction

  task automatic idle_inputs();
    ifu_cmd_valid = 1'b0;
    ifu_cmd_addr = '0;
    ifu_rsp_ready = 1'b1;
    ldr_cmd_valid = 1'b0;
    ldr_cmd_addr = '0;
    ldr_cmd_read = 1'b1;
    ldr_cmd_wdata = '0;
    ldr_cmd_wmask = '0;
    ldr_rsp_ready = 1'b1;
    loader_lock = 1'b0;
    itcm_cmd_ready = 1'b1;
    itcm_rsp_valid = 1'b0;
    itcm_rsp_rdata = '0;
  endtask

  task automatic settle();
    #3;
    model_eval();
  endtask

  task automatic advance();
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    idle_inputs();
    rst = 1'b1;
    ifu_cmd_valid = 1'b1;
    loader_lock = 1'b1;
    advance();
    advance();
    settle();
    obs = {itcm_cmd_valid, ifu_cmd_ready, ldr_cmd_ready,
           itcm_rsp_ready, ifu_rsp_valid, ldr_rsp_valid,
           lock_granted, arb_err, arb_idle};
    checks++;
    if (obs !== 9'b000000001) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=%b", obs, 9'b000000001);
    end
    rst = 1'b0;
    idle_inputs();
    advance();
    settle();
    obs = {3'b000, itcm_rsp_ready, 3'b000, arb_err, arb_idle};
    checks++;
    if (obs !== 9'b000100001) begin
      errors++;
      $display("FAIL post_reset got=%b exp=%b", obs, 9'b000100001);
    end
  endtask

  task automatic test_alternate();
    logic [AW-1:0] a, prev;
    logic [1:0] g, eg;
    idle_inputs();
    prev = '0;
    for (int k = 0; k < 5; k++) begin
      ifu_cmd_valid = (k < 4);
      ldr_cmd_valid = (k < 4);
      ifu_cmd_addr = AW'(16'h100 + 8 * k);
      ldr_cmd_addr = AW'(16'h200 + 8 * k);
      itcm_rsp_valid = (k >= 1);
      itcm_rsp_rdata = rd(prev);
      settle();
      if (k < 4) begin
        eg = (k % 2 == 0) ? 2'b10 : 2'b01;
        a = (k % 2 == 0) ? ifu_cmd_addr : ldr_cmd_addr;
        g = {ifu_cmd_ready, ldr_cmd_ready};
        checks++;
        if (g !== eg || itcm_cmd_addr !== a) begin
          errors++;
          $display("FAIL alt_grant k=%0d got=%b/%h exp=%b/%h",
                   k, g, itcm_cmd_addr, eg, a);
        end
        prev = a;
      end
      if (k >= 1) begin
        eg = ((k - 1) % 2 == 0) ? 2'b10 : 2'b01;
        g = {ifu_rsp_valid, ldr_rsp_valid};
        checks++;
        if (g !== eg || ldr_rsp_rdata !== itcm_rsp_rdata) begin
          errors++;
          $display("FAIL alt_rsp k=%0d got=%b exp=%b", k, g, eg);
        end
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_ifu_only();
    logic [AW-1:0] a;
    logic [1:0] g;
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      ifu_cmd_valid = (k < 4);
      ifu_cmd_addr = AW'(8 * k);
      itcm_rsp_valid = (k >= 1);
      a = AW'(8 * (k - 1));
      itcm_rsp_rdata = rd(a);
      settle();
      if (k < 4) begin
        checks++;
        if (ifu_cmd_ready !== 1'b1 || itcm_cmd_addr !== AW'(8 * k)) begin
          errors++;
          $display("FAIL ifu_cmd k=%0d got=%b/%h exp=1/%h",
                   k, ifu_cmd_ready, itcm_cmd_addr, AW'(8 * k));
        end
      end
      g = {ifu_rsp_valid, ldr_rsp_valid};
      checks++;
      if (g !== {k >= 1, 1'b0} ||
          (k >= 1 && ifu_rsp_rdata !== rd(a))) begin
        errors++;
        $display("FAIL ifu_rsp k=%0d got=%b/%h exp=%b/%h",
                 k, g, ifu_rsp_rdata, {k >= 1, 1'b0}, rd(a));
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    logic [1:0] g;
    idle_inputs();
    ifu_cmd_valid = 1'b1;
    ifu_cmd_addr = 16'h0300;
    for (int k = 0; k < 5; k++) begin
      itcm_rsp_valid = (k == 3);
      itcm_rsp_rdata = rd(16'h0300);
      settle();
      g = {itcm_cmd_valid, ifu_cmd_ready};
      checks++;
      if (g !== ((k == 2 || k == 3) ? 2'b00 : 2'b11)) begin
        errors++;
        $display("FAIL full_block k=%0d got=%b exp=%b", k, g,
                 (k == 2 || k == 3) ? 2'b00 : 2'b11);
      end
      if (k == 3) begin
        checks++;
        if (ifu_rsp_valid !== 1'b1) begin
          errors++;
          $display("FAIL full_rsp got=%b exp=1", ifu_rsp_valid);
        end
      end
      advance();
    end
    ifu_cmd_valid = 1'b0;
    itcm_rsp_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++;
      if (ifu_rsp_valid !== 1'b1 || itcm_rsp_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_drain k=%0d got=%b%b exp=11",
                 k, ifu_rsp_valid, itcm_rsp_ready);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    logic [1:0] g;
    idle_inputs();
    ifu_cmd_valid = 1'b1;
    ifu_cmd_addr = 16'h0400;
    settle();
    checks++;
    if (ifu_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL lock_pre got=%b exp=1", ifu_cmd_ready);
    end
    advance();
    loader_lock = 1'b1;
    ifu_cmd_addr = 16'h0408;
    for (int k = 0; k < 4; k++) begin
      itcm_rsp_valid = (k == 3);
      itcm_rsp_rdata = rd(16'h0400);
      settle();
      g = {lock_granted, ifu_cmd_ready};
      checks++;
      if (g !== 2'b00) begin
        errors++;
        $display("FAIL lock_wait k=%0d got=%b exp=00", k, g);
      end
      advance();
    end
    itcm_rsp_valid = 1'b0;
    ldr_cmd_valid = 1'b1;
    ldr_cmd_read = 1'b0;
    ldr_cmd_addr = 16'h0010;
    ldr_cmd_wdata = 64'hDEAD_BEEF_0123_4567;
    ldr_cmd_wmask = 8'hF0;
    settle();
    g = {lock_granted, ifu_cmd_ready};
    checks++;
    if (g !== 2'b10 || ldr_cmd_ready !== 1'b1 ||
        itcm_cmd_read !== 1'b0 || itcm_cmd_wmask !== 8'hF0 ||
        itcm_cmd_wdata !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL lock_grant got=%b ldr=%b rd=%b m=%h exp=10 1 0 f0",
               g, ldr_cmd_ready, itcm_cmd_read, itcm_cmd_wmask);
    end
    advance();
    ldr_cmd_valid = 1'b0;
    itcm_rsp_valid = 1'b1;
    settle();
    g = {ifu_rsp_valid, ldr_rsp_valid};
    checks++;
    if (g !== 2'b01) begin
      errors++;
      $display("FAIL lock_ldr_rsp got=%b exp=01", g);
    end
    advance();
    itcm_rsp_valid = 1'b0;
    loader_lock = 1'b0;
    settle();
    checks++;
    if (ifu_cmd_ready !== 1'b1 || itcm_cmd_addr !== 16'h0408) begin
      errors++;
      $display("FAIL unlock_ifu got=%b/%h exp=1/0408",
               ifu_cmd_ready, itcm_cmd_addr);
    end
    advance();
    ifu_cmd_valid = 1'b0;
    itcm_rsp_valid = 1'b1;
    settle();
    advance();
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [2:0] g;
    idle_inputs();
    itcm_cmd_ready = 1'b0;
    ifu_cmd_valid = 1'b1;
    ifu_cmd_addr = 16'h0500;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        ldr_cmd_valid = 1'b1;
        ldr_cmd_addr = 16'h0600;
      end
      settle();
      g = {itcm_cmd_valid, ifu_cmd_ready, ldr_cmd_ready};
      checks++;
      if (g !== 3'b100 || itcm_cmd_addr !== 16'h0500) begin
        errors++;
        $display("FAIL stall_hold k=%0d got=%b/%h exp=100/0500",
                 k, g, itcm_cmd_addr);
      end
      advance();
    end
    itcm_cmd_ready = 1'b1;
    settle();
    g = {itcm_cmd_valid, ifu_cmd_ready, ldr_cmd_ready};
    checks++;
    if (g !== 3'b110 || itcm_cmd_addr !== 16'h0500) begin
      errors++;
      $display("FAIL stall_rel got=%b/%h exp=110/0500", g, itcm_cmd_addr);
    end
    advance();
    ifu_cmd_valid = 1'b0;
    settle();
    checks++;
    if (ldr_cmd_ready !== 1'b1 || itcm_cmd_addr !== 16'h0600) begin
      errors++;
      $display("FAIL stall_ldr got=%b/%h exp=1/0600",
               ldr_cmd_ready, itcm_cmd_addr);
    end
    advance();
    ldr_cmd_valid = 1'b0;
    itcm_rsp_valid = 1'b1;
    settle();
    advance();
    settle();
    advance();
    idle_inputs();
  endtask

  task automatic test_err();
    logic [2:0] g;
    idle_inputs();
    settle();
    checks++;
    if (arb_err !== 1'b0 || arb_idle !== 1'b1) begin
      errors++;
      $display("FAIL err_pre got=%b%b exp=01", arb_err, arb_idle);
    end
    itcm_rsp_valid = 1'b1;
    settle();
    g = {itcm_rsp_ready, ifu_rsp_valid, ldr_rsp_valid};
    checks++;
    if (g !== 3'b100) begin
      errors++;
      $display("FAIL err_drop got=%b exp=100", g);
    end
    advance();
    itcm_rsp_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++;
      if (arb_err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky k=%0d got=%b exp=1", k, arb_err);
      end
      advance();
    end
    rst = 1'b1;
    advance();
    rst = 1'b0;
    settle();
    checks++;
    if (arb_err !== 1'b0 || arb_idle !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got=%b%b exp=01", arb_err, arb_idle);
    end
    advance();
  endtask

  task automatic test_random(input int n);
    logic [AW-1:0] itq[$];
    logic [DW-1:0] ifu_exp[$];
    logic [DW-1:0] ldr_exp[$];
    bit ldr_isrd[$];
    logic [8:0] obs, exp9;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit ifu_acc, ldr_acc, rsp_acc, hd;
    idle_inputs();
    for (int c = 0; c < n; c++) begin
      if (!ifu_cmd_valid && $urandom_range(0, 2) == 0) begin
        ifu_cmd_valid = 1'b1;
        ifu_cmd_addr = AW'($urandom) & 16'hFFF8;
      end
      if (!ldr_cmd_valid && $urandom_range(0, 2) == 0) begin
        ldr_cmd_valid = 1'b1;
        ldr_cmd_addr = AW'($urandom) & 16'hFFF8;
        ldr_cmd_read = 1'($urandom);
        ldr_cmd_wdata = {$urandom, $urandom};
        ldr_cmd_wmask = MW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) loader_lock = !loader_lock;
      itcm_cmd_ready = ($urandom_range(0, 3) != 0);
      if (!itcm_rsp_valid && itq.size() != 0 &&
          $urandom_range(0, 1) == 1) begin
        itcm_rsp_valid = 1'b1;
        itcm_rsp_rdata = rd(itq[0]);
      end
      ifu_rsp_ready = ($urandom_range(0, 3) != 0);
      ldr_rsp_ready = ($urandom_range(0, 3) != 0);
      settle();
      obs = {itcm_cmd_valid, ifu_cmd_ready, ldr_cmd_ready,
             itcm_rsp_ready, ifu_rsp_valid, ldr_rsp_valid,
             lock_granted, arb_idle, arb_err};
      exp9 = {e_cv, e_ir, e_lr, e_rr, e_irv, e_lrv, e_lg, e_idle, m_err};
      checks++;
      if (obs !== exp9) begin
        errors++;
        $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, obs, exp9);
      end
      ea = e_own ? ldr_cmd_addr : ifu_cmd_addr;
      if (e_cv) begin
        checks++;
        if (itcm_cmd_addr !== ea ||
            itcm_cmd_read !== (e_own ? ldr_cmd_read : 1'b1) ||
            itcm_cmd_wdata !== (e_own ? ldr_cmd_wdata : '0) ||
            itcm_cmd_wmask !== (e_own ? ldr_cmd_wmask : '0)) begin
          errors++;
          $display("FAIL rnd_cmd c=%0d got=%h/%b exp=%h/%b", c,
                   itcm_cmd_addr, itcm_cmd_read, ea,
                   e_own ? ldr_cmd_read : 1'b1);
        end
      end
      rsp_acc = itcm_rsp_valid && e_rr && (mq.size() != 0);
      hd = (mq.size() != 0) ? mq[0] : 1'b0;
      if (rsp_acc) begin
        void'(itq.pop_front());
        if (!hd) begin
          ed = ifu_exp.pop_front();
          checks++;
          if (ifu_rsp_rdata !== ed) begin
            errors++;
            $display("FAIL rnd_ifu_data c=%0d got=%h exp=%h",
                     c, ifu_rsp_rdata, ed);
          end
        end else begin
          ed = ldr_exp.pop_front();
          if (ldr_isrd.pop_front()) begin
            checks++;
            if (ldr_rsp_rdata !== ed) begin
              errors++;
              $display("FAIL rnd_ldr_data c=%0d got=%h exp=%h",
                       c, ldr_rsp_rdata, ed);
            end
          end
        end
      end
      ifu_acc = e_ir;
      ldr_acc = e_lr;
      if (ifu_acc || ldr_acc) begin
        itq.push_back(ea);
        if (ifu_acc) ifu_exp.push_back(rd(ea));
        else begin
          ldr_exp.push_back(rd(ea));
          ldr_isrd.push_back(ldr_cmd_read);
        end
      end
      advance();
      if (ifu_acc) ifu_cmd_valid = 1'b0;
      if (ldr_acc) ldr_cmd_valid = 1'b0;
      if (rsp_acc) itcm_rsp_valid = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_alternate();
    test_ifu_only();
    test_full();
    test_lock();
    test_stall();
    test_err();
    test_random(2000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
